// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register family: occupancy
// encoding, the NOP control bundle and saturating arithmetic.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Widest control bundle any stage may carry; instances slice it down.
    localparam int CTRL_MAX_W = 4096;

    function automatic logic [CTRL_MAX_W-1:0] ctrl_bubble();
        return '0;
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] lim);
        return (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; shared by stage
// performance counters.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // Clear wins over a coincident increment.
    always_ff @(posedge Clk) begin
        if (Reset || clr)
            r_count <= '0;
        else if (inc)
            r_count <= CNT_W'(sat_inc(64'(r_count), 64'(CNT_MAX)));
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, optional 2-entry skid
// buffer (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 256,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              ClrStat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(ctrl_bubble());

    logic [1:0]        r_state;
    logic              r_in_rdy;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_consume;
    logic [1:0]        w_next_state;

    assign out_valid = (r_state != ST_EMPTY);
    assign w_consume = out_valid && out_ready;

    // With the skid buffer, in_ready comes straight from a flop so the
    // downstream ready never ripples combinationally into upstream.
    always_comb begin
        w_in_ready = 1'b0;
        if (SKID != 0)
            w_in_ready = !Reset && r_in_rdy;
        else
            w_in_ready = !Reset && !Flush && (!out_valid || out_ready);
    end

    assign in_ready = w_in_ready;
    assign w_accept = in_valid && w_in_ready && !Flush;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_consume && (SKID != 0))
                    w_next_state = ST_TWO;
                else if (w_consume && !w_accept)
                    w_next_state = ST_EMPTY;
            end
            ST_TWO:   if (w_consume) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
        endcase
        if (Flush)
            w_next_state = ST_EMPTY;
    end

    // Main entry always holds the oldest beat; the skid entry only ever
    // feeds the main entry, which keeps ordering strictly FIFO.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_EMPTY;
            r_in_rdy    <= 1'b1;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state  <= w_next_state;
            r_in_rdy <= (w_next_state != ST_TWO);
            if (Flush) begin
                r_skid_ctrl <= '0;
                r_skid_data <= '0;
            end else if (r_state == ST_TWO && w_consume) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
                r_skid_ctrl <= '0;
                r_skid_data <= '0;
            end else if (w_accept && (r_state == ST_EMPTY || w_consume)) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_accept) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
        end
    end

    assign out_ctrl  = out_valid ? r_main_ctrl : CTRL_BUBBLE;
    assign out_data  = r_main_data;
    assign occupancy = r_state;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (out_valid && !out_ready),
        .clr   (ClrStat),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: dut 0 is SKID=1/CNT_W=16, dut 1 is SKID=0/CNT_W=4. A FIFO-level
// reference model checks both every cycle; table and hand sequences add corners.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          rst;
    logic          fl   [2];
    logic          clr  [2];
    logic          iv   [2];
    logic          ir   [2];
    logic          ov   [2];
    logic          ordy [2];
    logic [CW-1:0] ictl [2];
    logic [CW-1:0] octl [2];
    logic [DW-1:0] idat [2];
    logic [DW-1:0] odat [2];
    logic [1:0]    occ  [2];
    logic [15:0]   stl0;
    logic [3:0]    stl1;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_skid (
        .Clk(Clk), .Reset(rst), .Flush(fl[0]), .ClrStat(clr[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_ctrl(ictl[0]), .in_data(idat[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(octl[0]), .out_data(odat[0]),
        .occupancy(occ[0]), .stall_cycles(stl0));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(4)) u_nosk (
        .Clk(Clk), .Reset(rst), .Flush(fl[1]), .ClrStat(clr[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_ctrl(ictl[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(octl[1]), .out_data(odat[1]),
        .occupancy(occ[1]), .stall_cycles(stl1));

    int total = 0;
    int bad   = 0;

    // Reference model: up to two held beats per dut as a tiny FIFO.
    logic [CW-1:0] mctl  [2][2];
    logic [DW-1:0] mdat  [2][2];
    int            mcnt  [2];
    logic [DW-1:0] mlast [2];
    int            mstall[2];
    int            smax  [2];

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          rdy;
        logic          fl;
        logic          ov;
        logic [DW-1:0] od;
        logic [1:0]    occ;
        logic          ir;
        int            st;
    } vec_t;

    vec_t tab [23];
    logic tab_en = 1'b0;
    int   tab_idx = 0;

    logic          sb_en = 1'b0;
    logic [DW-1:0] sb [$];
    int            n_acc = 0;
    int            n_cons = 0;

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return 16'h5A00 ^ d[15:0];
    endfunction

    function automatic vec_t mk(input logic a, input int d, input logic r, input logic f,
                                input logic v, input int od, input int oc, input logic rd, input int st);
        vec_t t;
        t.iv = a; t.d = DW'(d); t.rdy = r; t.fl = f;
        t.ov = v; t.od = DW'(od); t.occ = 2'(oc); t.ir = rd; t.st = st;
        return t;
    endfunction

    function automatic logic exp_ir(input int k);
        if (k == 0) return !rst && (mcnt[0] < 2);
        return !rst && !fl[1] && (mcnt[1] == 0 || ordy[1]);
    endfunction

    task automatic hchk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chk(input int k);
        logic [CW-1:0] ectl;
        int st;
        ectl = (mcnt[k] > 0) ? mctl[k][0] : '0;
        st = (k == 0) ? int'(stl0) : int'(stl1);
        total++;
        if (ov[k] !== (mcnt[k] > 0) || octl[k] !== ectl || odat[k] !== mlast[k] ||
            occ[k] !== 2'(mcnt[k]) || ir[k] !== exp_ir(k) || st != mstall[k]) begin
            bad++;
            $display("FAIL model dut%0d t=%0t: got v=%b c=%h d=%h occ=%0d rdy=%b st=%0d want v=%b c=%h d=%h occ=%0d rdy=%b st=%0d",
                     k, $time, ov[k], octl[k], odat[k], occ[k], ir[k], st,
                     (mcnt[k] > 0), ectl, mlast[k], mcnt[k], exp_ir(k), mstall[k]);
        end
    endtask

    task automatic chk_tab(input int i);
        logic [CW-1:0] ectl;
        ectl = tab[i].ov ? ctrl_of(tab[i].od) : '0;
        total++;
        if (ov[0] !== tab[i].ov || odat[0] !== tab[i].od || octl[0] !== ectl ||
            occ[0] !== tab[i].occ || ir[0] !== tab[i].ir || int'(stl0) != tab[i].st) begin
            bad++;
            $display("FAIL tab row %0d: got v=%b d=%0d c=%h occ=%0d rdy=%b st=%0d want v=%b d=%0d c=%h occ=%0d rdy=%b st=%0d",
                     i, ov[0], odat[0], octl[0], occ[0], ir[0], stl0,
                     tab[i].ov, tab[i].od, ectl, tab[i].occ, tab[i].ir, tab[i].st);
        end
    endtask

    task automatic sb_step();
        hchk("nosk_ready", int'(ir[1]), int'(ordy[1] || !ov[1]));
        if (ov[1] && ordy[1]) begin
            n_cons++;
            if (sb.size() == 0) begin
                hchk("sb_spurious", 1, 0);
            end else begin
                logic [DW-1:0] w;
                w = sb.pop_front();
                hchk("sb_data", int'(odat[1]), int'(w));
            end
        end
        if (iv[1] && ir[1]) begin
            sb.push_back(idat[1]);
            n_acc++;
        end
    endtask

    task automatic model_edge(input int k);
        logic acc, cons;
        if (rst) begin
            mcnt[k] = 0; mlast[k] = '0; mstall[k] = 0;
            return;
        end
        acc  = iv[k] && exp_ir(k) && !fl[k];
        cons = (mcnt[k] > 0) && ordy[k];
        if (clr[k]) mstall[k] = 0;
        else if (mcnt[k] > 0 && !ordy[k] && mstall[k] < smax[k]) mstall[k]++;
        if (fl[k]) begin
            mcnt[k] = 0;
        end else begin
            if (cons) begin
                mctl[k][0] = mctl[k][1]; mdat[k][0] = mdat[k][1]; mcnt[k]--;
            end
            if (acc) begin
                mctl[k][mcnt[k]] = ictl[k]; mdat[k][mcnt[k]] = idat[k]; mcnt[k]++;
            end
        end
        if (mcnt[k] > 0) mlast[k] = mdat[k][0];
    endtask

    task automatic tick();
        @(negedge Clk);
        for (int k = 0; k < 2; k++) chk(k);
        if (tab_en) chk_tab(tab_idx);
        if (sb_en) sb_step();
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        //            iv  d   rdy fl  ov  od  occ ir  st
        tab[0]  = mk(1,  1, 1, 0, 0,  0, 0, 1, 0);
        tab[1]  = mk(1,  2, 1, 0, 1,  1, 1, 1, 0);
        tab[2]  = mk(1,  3, 1, 0, 1,  2, 1, 1, 0);
        tab[3]  = mk(1,  4, 1, 0, 1,  3, 1, 1, 0);
        tab[4]  = mk(0,  0, 1, 0, 1,  4, 1, 1, 0);
        tab[5]  = mk(0,  0, 0, 0, 0,  4, 0, 1, 0);
        tab[6]  = mk(1, 10, 0, 0, 0,  4, 0, 1, 0);
        tab[7]  = mk(1, 11, 0, 0, 1, 10, 1, 1, 0);
        tab[8]  = mk(1, 12, 0, 0, 1, 10, 2, 0, 1);
        tab[9]  = mk(1, 12, 0, 0, 1, 10, 2, 0, 2);
        tab[10] = mk(1, 12, 0, 0, 1, 10, 2, 0, 3);
        tab[11] = mk(1, 12, 1, 0, 1, 10, 2, 0, 4);
        tab[12] = mk(1, 12, 1, 0, 1, 11, 1, 1, 4);
        tab[13] = mk(0,  0, 1, 0, 1, 12, 1, 1, 4);
        tab[14] = mk(0,  0, 0, 0, 0, 12, 0, 1, 4);
        tab[15] = mk(1, 20, 0, 0, 0, 12, 0, 1, 4);
        tab[16] = mk(1, 21, 0, 0, 1, 20, 1, 1, 4);
        tab[17] = mk(1, 99, 0, 1, 1, 20, 2, 0, 5);
        tab[18] = mk(0,  0, 1, 0, 0, 20, 0, 1, 6);
        tab[19] = mk(1, 30, 0, 0, 0, 20, 0, 1, 6);
        tab[20] = mk(1, 99, 1, 1, 1, 30, 1, 1, 6);
        tab[21] = mk(0,  0, 1, 0, 0, 30, 0, 1, 6);
        tab[22] = mk(0,  0, 1, 0, 0, 30, 0, 1, 6);

        smax[0] = 65535; smax[1] = 15;
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mlast[k] = '0; mstall[k] = 0;
            for (int j = 0; j < 2; j++) begin mctl[k][j] = '0; mdat[k][j] = '0; end
            fl[k] = 0; clr[k] = 0; iv[k] = 1; ordy[k] = 0;
            ictl[k] = 16'hABCD; idat[k] = 32'hDEAD_BEEF;
        end

        // Reset with a beat on offer: nothing may be accepted.
        rst = 1;
        repeat (2) tick();
        rst = 0;

        iv[1] = 0; ordy[1] = 1;
        tab_en = 1;
        for (int i = 0; i < 23; i++) begin
            iv[0] = tab[i].iv; idat[0] = tab[i].d; ictl[0] = ctrl_of(tab[i].d);
            ordy[0] = tab[i].rdy; fl[0] = tab[i].fl;
            tab_idx = i;
            tick();
        end
        tab_en = 0;
        iv[0] = 0; ordy[0] = 1; fl[0] = 0;

        // Single-entry stage under toggling backpressure.
        sb_en = 1; iv[1] = 1;
        for (int i = 0; i < 8; i++) begin
            idat[1] = DW'(100 + i); ictl[1] = ctrl_of(DW'(100 + i));
            ordy[1] = (i % 2 == 0);
            tick();
        end
        iv[1] = 0; ordy[1] = 1;
        repeat (3) tick();
        sb_en = 0;
        hchk("sb_drain", sb.size(), 0);
        hchk("sb_acc", n_acc, 4);
        hchk("sb_cons", n_cons, n_acc);

        // Stall counter saturation and clear on the 4-bit counter.
        clr[1] = 1; iv[1] = 1; idat[1] = 200; ictl[1] = ctrl_of(200); ordy[1] = 0;
        tick();
        clr[1] = 0; iv[1] = 0;
        repeat (20) tick();
        hchk("stall_sat", int'(stl1), 15);
        clr[1] = 1;
        tick();
        hchk("stall_clr", int'(stl1), 0);
        clr[1] = 0;
        tick();
        hchk("stall_after_clr", int'(stl1), 1);
        ordy[1] = 1;
        tick();

        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                ictl[k] = CW'($urandom);
                idat[k] = $urandom;
                ordy[k] = ($urandom_range(0, 4) > c / 150);
                fl[k]   = ($urandom_range(0, 15) == 0);
                clr[k]  = ($urandom_range(0, 31) == 0);
            end
            tick();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed pipeline stage registers between processor stages (ID/EX, EX/MEM, MEM/WB). It carries one control bundle and one data bundle per beat and adds a valid/ready handshake, so a stall in a later stage back-pressures earlier ones instead of being handled by ad-hoc gating. It also supports flush (bubble insertion), an optional 2-entry skid buffer that breaks the combinational ready path, and a saturating stall-cycle counter for performance analysis.

Parameters:
CTRL_W, 16, width of the control bundle; all-zero control is the defined bubble (NOP).
DATA_W, 256, width of the data bundle (PC+4, PC+imm, ALU result, Hi/Lo, operands, destination register, concatenated by the instantiating stage).
SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready.
CNT_W, 16, width of the stall-cycle counter.

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
Flush  in  1  kill all held beats (branch mispredict / exception)
ClrStat  in  1  synchronous clear of stall_cycles
in_valid  in  1  upstream beat present
in_ready  out  1  this stage accepts a beat this cycle
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  beat present for downstream
out_ready  in  1  downstream accepts this cycle
out_ctrl  out  CTRL_W  control bundle; forced to 0 when out_valid=0
out_data  out  DATA_W  data bundle
occupancy  out  2  number of held beats (0..2)
stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshake rules:
  - An upstream beat is accepted when in_valid && in_ready.
  - A downstream beat is consumed when out_valid && out_ready.
  - Latency from accept to out_valid is 1 cycle. There is no same-cycle pass-through.
- Reset (while Reset=1, taking effect at the clock edge):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0.
  - The skid entry is cleared.
  - in_ready=0 while Reset is high.
- Bubble: out_ctrl is 0 whenever out_valid=0. out_data holds its last value when invalid; it is zeroed only by Reset.
- SKID=0 (single entry, states EMPTY/ONE):
  - in_ready = !Reset && !Flush && (!out_valid || out_ready).
  - An accept loads the main register; the state is ONE after the edge.
  - A consume without an accept moves the state to EMPTY.
  - Accept and consume in the same cycle keep the state at ONE with the new beat.
- SKID=1 (states EMPTY, ONE, TWO; main register plus skid register):
  - in_ready is registered: 1 in EMPTY and ONE, 0 in TWO, and 0 in the cycle after Reset or Flush deasserts only if the state is TWO.
  - EMPTY, accept -> ONE (load main).
  - ONE, accept && consume -> ONE (main replaced).
  - ONE, accept && !consume -> TWO (beat stored in skid).
  - ONE, consume only -> EMPTY.
  - TWO, consume -> ONE (skid moves to main; skid cleared).
  - TWO, no consume -> TWO (both entries hold; no accept is possible).
  - Ordering is strict FIFO: the skid beat never overtakes the main beat.
- Flush: when Flush=1 at an edge, the state becomes EMPTY, out_valid=0, out_ctrl=0, and the skid is invalidated. A beat offered in the flush cycle is not accepted (in_ready=0 for SKID=0; for SKID=1 it is dropped). Flush has priority over accept and consume. Reset has priority over Flush.
- occupancy = 0/1/2 for EMPTY/ONE/TWO, registered.
- stall_cycles:
  - Increments at each edge where out_valid && !out_ready held in the preceding cycle.
  - Saturates at 2^CNT_W-1 with no wrap.
  - ClrStat=1 zeroes it at the edge. If ClrStat and a stall coincide, the result is 0.
- No X propagation: all storage has a defined reset value; no initial blocks are required.

Decomposition:
- Package pipe_pkg holds:
  - the occupancy state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2);
  - the helper constant CTRL_BUBBLE = '0 (sized per instance via a function);
  - the saturating-increment function.
- One sub-module is natural: pipe_sat_counter (CNT_W parameter; inputs inc and clr; output count). It is reused by other stages' performance counters.

Test Plan:
- Reset held 2 cycles with in_valid=1, in_ctrl=16'hABCD -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0, occupancy=0, stall_cycles=0.
- SKID=1, stream 4 beats (data 1..4) with out_ready=1 -> outputs 1,2,3,4 on consecutive cycles, each 1 cycle after accept; occupancy stays 1.
- SKID=1, out_ready=0 for 5 cycles while offering beats 10,11,12 -> 10 and 11 accepted, occupancy=2, in_ready=0, stall_cycles=4. Raise out_ready -> 10 then 11 emitted, then 12 accepted.
- Flush in the TWO state while offering beat 99 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; beat 99 never appears at the output.
- SKID=0, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready equals out_ready||!out_valid each cycle; no beat lost or duplicated (scoreboard).
- CNT_W=4, hold a stall for 20 cycles -> stall_cycles saturates at 15. ClrStat for 1 cycle with the stall ongoing -> stall_cycles=0, then 1 the following cycle.
